// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/SLT, iterative SLL, valid/ready on both sides.
// Optional signed-overflow output when ALU_OVF_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ALU_control,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
`ifdef ALU_OVF_EN
    output logic               overflow,
`endif
    output logic               zero
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   op_res;
    logic [WIDTH-1:0]   shl_res;
    logic               accept;
    logic               sll_multi;

    // Single-cycle result; SLL here only covers the zero-shift case.
    function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] code,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        a_s = a;
        b_s = b;
        case (code)
            OP_ADD:  alu_op = a + b;
            OP_SUB:  alu_op = a - b;
            OP_AND:  alu_op = a & b;
            OP_OR:   alu_op = a | b;
            OP_SLT:  alu_op = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLL:  alu_op = b;
            default: alu_op = '0;
        endcase
    endfunction

`ifdef ALU_OVF_EN
    function automatic logic alu_ovf(input logic [2:0] code,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] dif;
        sum = a + b;
        dif = a - b;
        case (code)
            OP_ADD:  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            default: alu_ovf = 1'b0;
        endcase
    endfunction
`endif

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign sll_multi = (ALU_control == OP_SLL) && (shamt != '0);
    assign op_res    = alu_op(ALU_control, src_a, src_b);
    // The result register doubles as the shift accumulator while in SHIFT.
    assign shl_res   = {result[WIDTH-2:0], 1'b0};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            cnt       <= '0;
`ifdef ALU_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (sll_multi) begin
                            state     <= SHIFT;
                            out_valid <= 1'b0;
                            result    <= src_b;
                            cnt       <= shamt;
`ifdef ALU_OVF_EN
                            overflow  <= 1'b0;
`endif
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            result    <= op_res;
                            zero      <= (op_res == '0);
                            cnt       <= '0;
`ifdef ALU_OVF_EN
                            overflow  <= alu_ovf(ALU_control, src_a, src_b);
`endif
                        end
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    result <= shl_res;
                    cnt    <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        zero      <= (shl_res == '0);
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at accept, compared at output handshake.
module tb_alu_exec_unit;

    localparam int W = 32;
    localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010, C_SLL = 3'b011,
                           C_SUB = 3'b110, C_SLT = 3'b111;

    logic         CLK, RST;
    logic         in_valid, in_ready, out_valid, out_ready, zero;
    logic [2:0]   ALU_control;
    logic [W-1:0] src_a, src_b, result;
    logic [4:0]   shamt;
`ifdef ALU_OVF_EN
    logic         overflow;
`endif

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_control(ALU_control), .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
`ifdef ALU_OVF_EN
        .overflow(overflow),
`endif
        .zero(zero)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [2:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [4:0] s);
        case (c)
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLL:   return b << s;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (c == C_ADD)      r = sa + sb;
        else if (c == C_SUB) r = sa - sb;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic push_exp(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] s);
        exp_t e;
        e.r = ref_res(c, a, b, s);
        e.z = (e.r == '0);
        e.o = ref_ovf(c, a, b);
        q.push_back(e);
    endtask

    // Offers one op, waits (bounded) for in_ready, returns at posedge+1 after the accept edge.
    task automatic do_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] s);
        int n = 0;
        ALU_control = c; src_a = a; src_b = b; shamt = s; in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        else push_exp(c, a, b, s);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.r);
                chk("zero", 32'(zero), 32'(e.z));
`ifdef ALU_OVF_EN
                chk("overflow", 32'(overflow), 32'(e.o));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CLK = 0; RST = 1; in_valid = 0; out_ready = 1;
        ALU_control = '0; src_a = '0; src_b = '0; shamt = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
`ifdef ALU_OVF_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        @(negedge CLK);
        RST = 0;
        @(posedge CLK);
        #1;

        // single-cycle latency
        do_op(C_ADD, 32'd5, 32'd7, 5'd0);
        chk("add_lat_valid", 32'(out_valid), 32'd1);
        chk("add_lat_result", result, 32'd12);
        chk("add_lat_zero", 32'(zero), 32'd0);
        @(posedge CLK);
        #1;
        chk("idle_after_consume", 32'(out_valid), 32'd0);

        // back-to-back single-cycle ops through the scoreboard
        do_op(C_SUB, 32'd9, 32'd9, 5'd0);
        do_op(C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        do_op(C_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0);
        do_op(C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        do_op(C_OR, 32'h1200_0000, 32'h0000_0034, 5'd0);
        do_op(C_SUB, 32'd3, 32'd5, 5'd0);
        do_op(3'b100, 32'h1234, 32'h5678, 5'd0);
        do_op(3'b101, 32'hFFFF, 32'h1, 5'd0);
        do_op(C_SLL, 32'd0, 32'hABCD, 5'd0);
        chk("sll0_lat_result", result, 32'hABCD);
        for (int i = 0; i < 6; i++)
            do_op(3'($urandom_range(7)), $urandom, $urandom, 5'($urandom_range(3)));
        drain();

        // iterative shift: busy for shamt cycles
        do_op(C_SLL, 32'd0, 32'd1, 5'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("sll_busy_in_ready", 32'(in_ready), 32'd0);
            chk("sll_busy_out_valid", 32'(out_valid), 32'd0);
            @(posedge CLK);
            #1;
        end
        chk("sll_done_valid", 32'(out_valid), 32'd1);
        chk("sll_done_result", result, 32'h10);
        // a pending offer during SHIFT must wait for the shift to finish
        do_op(C_SLL, 32'd0, 32'd3, 5'd31);
        do_op(C_ADD, 32'd100, 32'd1, 5'd0);
        do_op(C_SLL, 32'd0, 32'h8000_0000, 5'd1);
        do_op(C_SLL, 32'd0, 32'h0000_0F0F, 5'd13);
        drain();

        // backpressure, then simultaneous consume+accept
        out_ready = 0;
        do_op(C_ADD, 32'd20, 32'd22, 5'd0);
        ALU_control = C_OR; src_a = 32'hF0; src_b = 32'h0F; shamt = '0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'd42);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge CLK);
            #1;
        end
        out_ready = 1;
        push_exp(C_OR, 32'hF0, 32'h0F, 5'd0);
        @(posedge CLK);
        #1;
        in_valid = 0;
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_result", result, 32'hFF);
        drain();

        // reset in the middle of a long shift
        ALU_control = C_SLL; src_a = '0; src_b = 32'h5; shamt = 5'd20; in_valid = 1;
        @(posedge CLK);
        #1;
        in_valid = 0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        RST = 1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RST = 0;
        @(posedge CLK);
        #1;
        do_op(C_ADD, 32'd40, 32'd2, 5'd0);
        chk("post_rst_result", result, 32'd42);
        drain();

`ifdef ALU_OVF_EN
        do_op(C_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("ovf_add_result", result, 32'h8000_0000);
        chk("ovf_add_flag", 32'(overflow), 32'd1);
        do_op(C_SUB, 32'h8000_0000, 32'd1, 5'd0);
        chk("ovf_sub_flag", 32'(overflow), 32'd1);
        do_op(C_ADD, 32'd1, 32'd1, 5'd0);
        chk("ovf_none_flag", 32'(overflow), 32'd0);
        do_op(C_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        do_op(C_OR, 32'h7FFF_FFFF, 32'h1, 5'd0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
